// File: rtl/tamaquar_button_ctrl.sv
// Key front-end for the TamaQuar pet FSM: 2-flop sync, debounce, active-low press pulses, short/long select decode.
// Optional auto-repeat on feed/heal while held is built when TAMAQUAR_AUTO_REPEAT_EN is defined.
module tamaquar_button_ctrl #(
    parameter int DEB_CYCLES    = 1000000,
    parameter int LONG_CYCLES   = 100000000,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_feed_n,
    input  logic btn_light_n,
    input  logic btn_echo_n,
    input  logic btn_heal_n,
    input  logic btn_sel_n,
    output logic feeding1,
    output logic light_out1,
    output logic echo_sig1,
    output logic healing1,
    output logic change_state1,
    output logic test1,
    output logic sel_long
);
    localparam int NKEY = 5;
    localparam int SEL  = 4;
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int LW   = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    logic [NKEY-1:0] key_raw;
    logic [NKEY-1:0] sync_a;
    logic [NKEY-1:0] sync_b;
    deb_state_t      state     [NKEY];
    deb_state_t      state_nxt [NKEY];
    logic [DW-1:0]   cnt       [NKEY];
    logic [DW-1:0]   cnt_nxt   [NKEY];
    logic [NKEY-1:0] press_acc;
    logic [NKEY-1:0] rel_acc;
    logic [NKEY-1:0] key_down;
    logic [3:0]      rep_fire;
    logic [3:0]      key_pulse_n;
    logic [LW-1:0]   hold_cnt;

    assign key_raw = {btn_sel_n, btn_heal_n, btn_echo_n, btn_light_n, btn_feed_n};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a <= '1;
            sync_b <= '1;
            for (int k = 0; k < NKEY; k++) begin
                state[k] <= IDLE;
                cnt[k]   <= '0;
            end
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;
            for (int k = 0; k < NKEY; k++) begin
                state[k] <= state_nxt[k];
                cnt[k]   <= cnt_nxt[k];
            end
        end
    end

    // Counters stop at DEB_MAX because reaching it always leaves the wait state.
    always_comb begin
        press_acc = '0;
        rel_acc   = '0;
        key_down  = '0;
        for (int k = 0; k < NKEY; k++) begin
            state_nxt[k] = state[k];
            cnt_nxt[k]   = cnt[k];
            key_down[k]  = (state[k] == HELD) || (state[k] == RELEASE_WAIT);
            case (state[k])
                IDLE: begin
                    if (!sync_b[k]) begin
                        state_nxt[k] = PRESS_WAIT;
                        cnt_nxt[k]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync_b[k]) begin
                        state_nxt[k] = IDLE;
                    end else if (cnt[k] == DEB_MAX) begin
                        state_nxt[k] = HELD;
                        press_acc[k] = 1'b1;
                    end else begin
                        cnt_nxt[k] = cnt[k] + DW'(1);
                    end
                end
                HELD: begin
                    if (sync_b[k]) begin
                        state_nxt[k] = RELEASE_WAIT;
                        cnt_nxt[k]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync_b[k]) begin
                        state_nxt[k] = HELD;
                    end else if (cnt[k] == DEB_MAX) begin
                        state_nxt[k] = IDLE;
                        rel_acc[k]   = 1'b1;
                    end else begin
                        cnt_nxt[k] = cnt[k] + DW'(1);
                    end
                end
                default: begin
                    state_nxt[k] = IDLE;
                end
            endcase
        end
    end

`ifdef TAMAQUAR_AUTO_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPW-1:0] REP_MAX  = RPW'(REPEAT_CYCLES - 1);
    localparam logic [3:0]     REP_KEYS = 4'b1001;

    logic [RPW-1:0] rep_cnt [4];

    // Period restarts from every pulse; a release glitch at the period boundary skips that repeat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) rep_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (press_acc[k]) begin
                    rep_cnt[k] <= '0;
                end else if (key_down[k] && !rel_acc[k]) begin
                    rep_cnt[k] <= (rep_cnt[k] == REP_MAX) ? '0 : rep_cnt[k] + RPW'(1);
                end
            end
        end
    end

    always_comb begin
        rep_fire = '0;
        for (int k = 0; k < 4; k++) begin
            rep_fire[k] = REP_KEYS[k] && key_down[k] && !rel_acc[k] && !sync_b[k]
                          && (rep_cnt[k] == REP_MAX);
        end
    end
`else
    assign rep_fire = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            key_pulse_n <= '1;
        end else begin
            key_pulse_n <= ~(press_acc[3:0] | rep_fire);
        end
    end

    assign feeding1   = key_pulse_n[0];
    assign light_out1 = key_pulse_n[1];
    assign echo_sig1  = key_pulse_n[2];
    assign healing1   = key_pulse_n[3];

    // A long press owns its release: change_state1 only fires if test1 never did.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt      <= '0;
            sel_long      <= 1'b0;
            change_state1 <= 1'b1;
            test1         <= 1'b1;
        end else begin
            change_state1 <= 1'b1;
            test1         <= 1'b1;
            if (press_acc[SEL]) begin
                hold_cnt <= '0;
            end else if (rel_acc[SEL]) begin
                change_state1 <= sel_long;
                sel_long      <= 1'b0;
            end else if (key_down[SEL] && !sel_long) begin
                if (hold_cnt == LONG_MAX) begin
                    test1    <= 1'b0;
                    sel_long <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tamaquar_button_ctrl.sv
// Bench for tamaquar_button_ctrl: directed scenarios with hand-derived timing, then random keys vs a run-length model.
module tb_tamaquar_button_ctrl;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    localparam logic [6:0] IDLE_OUT = 7'b1111110;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] keys = 5'b11111;
    logic feeding1, light_out1, echo_sig1, healing1, change_state1, test1, sel_long;
    logic [6:0] outs;

    int errors = 0;
    int checks = 0;

    // Reference model state: synchroniser delay line plus run-length debounce per key.
    logic       m_s1 [5];
    logic       m_s2 [5];
    logic       m_down [5];
    int         m_run [5];
    int         m_rep [5];
    int         m_age;
    logic       m_long;
    logic [6:0] m_exp;

    always #5 clk = ~clk;

    assign outs = {feeding1, light_out1, echo_sig1, healing1, change_state1, test1, sel_long};

    tamaquar_button_ctrl #(
        .DEB_CYCLES   (DEB),
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_feed_n   (keys[0]),
        .btn_light_n  (keys[1]),
        .btn_echo_n   (keys[2]),
        .btn_heal_n   (keys[3]),
        .btn_sel_n    (keys[4]),
        .feeding1     (feeding1),
        .light_out1   (light_out1),
        .echo_sig1    (echo_sig1),
        .healing1     (healing1),
        .change_state1(change_state1),
        .test1        (test1),
        .sel_long     (sel_long)
    );

    task automatic test_reset;
        rst  = 1'b0;
        keys = 5'b11111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== IDLE_OUT) begin
                errors++;
                $display("FAIL reset_hold c=%0d got=%b want=%b", c, outs, IDLE_OUT);
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== IDLE_OUT) begin
                errors++;
                $display("FAIL post_reset_idle c=%0d got=%b want=%b", c, outs, IDLE_OUT);
            end
        end
    endtask

    task automatic test_feed;
        logic [6:0] exp;
        keys[0] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            exp = IDLE_OUT;
`ifdef TAMAQUAR_AUTO_REPEAT_EN
            if (c >= 2 + DEB && c <= 30 && (c - (2 + DEB)) % REP == 0) exp[6] = 1'b0;
`else
            if (c == 2 + DEB) exp[6] = 1'b0;
`endif
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL feed_press c=%0d got=%b want=%b", c, outs, exp);
            end
            if (c == 29) keys[0] = 1'b1;
        end
    endtask

    task automatic test_heal_bounce;
        logic [6:0] exp;
        keys[3] = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            exp = IDLE_OUT;
            if (c == 4 + 2 + DEB) exp[3] = 1'b0;
`ifdef TAMAQUAR_AUTO_REPEAT_EN
            if (c == 4 + 2 + DEB + REP) exp[3] = 1'b0;
`endif
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL heal_bounce c=%0d got=%b want=%b", c, outs, exp);
            end
            case (c)
                0: keys[3] = 1'b1;
                1: keys[3] = 1'b0;
                2: keys[3] = 1'b1;
                3: keys[3] = 1'b0;
                20: keys[3] = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic test_sel_short;
        logic [6:0] exp;
        keys[4] = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            exp = IDLE_OUT;
            if (c == 10 + 2 + DEB) exp[2] = 1'b0;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL sel_short c=%0d got=%b want=%b", c, outs, exp);
            end
            if (c == 9) keys[4] = 1'b1;
        end
    endtask

    task automatic test_sel_long;
        logic [6:0] exp;
        keys[4] = 1'b0;
        for (int c = 0; c < 55; c++) begin
            @(negedge clk);
            exp = IDLE_OUT;
            if (c == 2 + DEB + LONG) exp[1] = 1'b0;
            if (c >= 2 + DEB + LONG && c < 40 + 2 + DEB) exp[0] = 1'b1;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL sel_long c=%0d got=%b want=%b", c, outs, exp);
            end
            if (c == 39) keys[4] = 1'b1;
        end
    endtask

    task automatic test_reset_mid;
        logic [6:0] exp;
        keys[1] = 1'b0;
        keys[2] = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            exp = IDLE_OUT;
            if (c == 4 + 2 + DEB) begin
                exp[5] = 1'b0;
                exp[4] = 1'b0;
            end
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL reset_mid c=%0d got=%b want=%b", c, outs, exp);
            end
            if (c == 2) rst = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 15) begin
                keys[1] = 1'b1;
                keys[2] = 1'b1;
            end
        end
    endtask

    // Advances the model by one clock edge using the inputs that edge will sample.
    task automatic model_step;
        logic       s;
        logic       qual;
        logic       pr;
        logic       rl;
        logic [6:0] e;
        if (!rst) begin
            for (int k = 0; k < 5; k++) begin
                m_s1[k]   = 1'b1;
                m_s2[k]   = 1'b1;
                m_down[k] = 1'b0;
                m_run[k]  = 0;
                m_rep[k]  = 0;
            end
            m_age  = 0;
            m_long = 1'b0;
            m_exp  = IDLE_OUT;
        end else begin
            e = IDLE_OUT;
            for (int k = 0; k < 5; k++) begin
                s    = m_s2[k];
                qual = m_down[k] ? s : !s;
                pr   = 1'b0;
                rl   = 1'b0;
                if (qual) begin
                    m_run[k]++;
                    if (m_run[k] == DEB + 1) begin
                        m_run[k]  = 0;
                        m_down[k] = !m_down[k];
                        if (m_down[k]) pr = 1'b1;
                        else rl = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (k < 4) begin
                    if (pr) e[6-k] = 1'b0;
`ifdef TAMAQUAR_AUTO_REPEAT_EN
                    if (k == 0 || k == 3) begin
                        if (pr) m_rep[k] = 0;
                        else if (m_down[k]) begin
                            if (m_rep[k] == REP - 1) begin
                                m_rep[k] = 0;
                                if (!s) e[6-k] = 1'b0;
                            end else begin
                                m_rep[k]++;
                            end
                        end
                    end
`endif
                end else begin
                    if (rl) begin
                        if (!m_long) e[2] = 1'b0;
                        m_long = 1'b0;
                    end else if (pr) begin
                        m_age = 0;
                    end else if (m_down[k] && !m_long) begin
                        m_age++;
                        if (m_age == LONG) begin
                            e[1]   = 1'b0;
                            m_long = 1'b1;
                        end
                    end
                end
            end
            e[0]  = m_long;
            m_exp = e;
            for (int k = 0; k < 5; k++) begin
                m_s2[k] = m_s1[k];
                m_s1[k] = keys[k];
            end
        end
    endtask

    task automatic test_random;
        int dur [5];
        int r;
        rst  = 1'b0;
        keys = 5'b11111;
        model_step();
        @(negedge clk);
        checks++;
        if (outs !== m_exp) begin
            errors++;
            $display("FAIL random_start got=%b want=%b", outs, m_exp);
        end
        for (int k = 0; k < 5; k++) dur[k] = $urandom_range(0, 20);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (dur[k] == 0) begin
                    keys[k] = ~keys[k];
                    r = $urandom_range(0, 9);
                    if (r < 3) dur[k] = $urandom_range(0, 2);
                    else if (r < 8) dur[k] = $urandom_range(4, 15);
                    else dur[k] = $urandom_range(20, 45);
                end else begin
                    dur[k]--;
                end
            end
            model_step();
            @(negedge clk);
            checks++;
            if (outs !== m_exp) begin
                errors++;
                $display("FAIL random c=%0d got=%b want=%b keys=%b", c, outs, m_exp, keys);
            end
        end
    endtask

    initial begin
        test_reset();
        test_feed();
        test_heal_bounce();
        test_sel_short();
        test_sel_long();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
